vga_controller: RTL and testbench



---
 rtl/vga_controller.sv | 133 +++++++++++++
 tb/tb_vga_controller.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/vga_controller.sv
// 640x480@60Hz VGA timing generator with an 8-colour vertical bar test pattern.
// The pixel clock is CLOCK_50/2; all outputs update together as VGA_CLK falls.
module vga_controller #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    output logic [7:0] VGA_B,
    output logic       VGA_BLANK_N,
    output logic       VGA_CLK,
    output logic [7:0] VGA_G,
    output logic       VGA_HS,
    output logic [7:0] VGA_R,
    output logic       VGA_SYNC_N,
    output logic       VGA_VS
);

    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam int         BAR_W    = H_ACTIVE / 8;

    logic       pix_clk_reg;
    logic       tick;
    logic [9:0] h_reg, h_next;
    logic [9:0] v_reg, v_next;
    logic       hs_reg, hs_next;
    logic       vs_reg, vs_next;
    logic       blank_n_reg, blank_n_next;
    logic [7:0] r_reg, r_next;
    logic [7:0] g_reg, g_next;
    logic [7:0] b_reg, b_next;
    logic [6:0] past_edge;
    logic [2:0] bar;
    logic [2:0] code;

    // Pixel work happens on the cycle where the divided clock is high, so the
    // registered outputs move on its falling edge and settle before the DAC samples.
    assign tick = pix_clk_reg;

    // Bar index from range compares against each bar boundary.
    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_bar_edge
            assign past_edge[gi] = (h_reg >= 10'((gi + 1) * BAR_W));
        end
    endgenerate

    always_comb begin
        bar = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (past_edge[i]) begin
                bar = bar + 3'd1;
            end
        end
        code = 3'd7 - bar;
    end

    always_comb begin
        h_next = h_reg + 10'd1;
        v_next = v_reg;
        if (h_reg == H_LAST) begin
            h_next = 10'd0;
            if (v_reg == V_LAST) begin
                v_next = 10'd0;
            end else begin
                v_next = v_reg + 10'd1;
            end
        end
    end

    always_comb begin
        hs_next      = !((h_reg >= HS_FIRST) && (h_reg <= HS_LAST));
        vs_next      = !((v_reg >= VS_FIRST) && (v_reg <= VS_LAST));
        blank_n_next = (h_reg < H_VIS) && (v_reg < V_VIS);
        r_next       = 8'h00;
        g_next       = 8'h00;
        b_next       = 8'h00;
        if (blank_n_next) begin
            r_next = code[1] ? 8'hFF : 8'h00;
            g_next = code[2] ? 8'hFF : 8'h00;
            b_next = code[0] ? 8'hFF : 8'h00;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            pix_clk_reg <= 1'b0;
            h_reg       <= 10'd0;
            v_reg       <= 10'd0;
            hs_reg      <= 1'b1;
            vs_reg      <= 1'b1;
            blank_n_reg <= 1'b0;
            r_reg       <= 8'h00;
            g_reg       <= 8'h00;
            b_reg       <= 8'h00;
        end else begin
            pix_clk_reg <= ~pix_clk_reg;
            if (tick) begin
                h_reg       <= h_next;
                v_reg       <= v_next;
                hs_reg      <= hs_next;
                vs_reg      <= vs_next;
                blank_n_reg <= blank_n_next;
                r_reg       <= r_next;
                g_reg       <= g_next;
                b_reg       <= b_next;
            end
        end
    end

    assign VGA_CLK     = pix_clk_reg;
    assign VGA_HS      = hs_reg;
    assign VGA_VS      = vs_reg;
    assign VGA_BLANK_N = blank_n_reg;
    assign VGA_R       = r_reg;
    assign VGA_G       = g_reg;
    assign VGA_B       = b_reg;
    assign VGA_SYNC_N  = 1'b0;

endmodule

// File: tb/tb_vga_controller.sv
// Directed bench for vga_controller: line timing and pattern on the full-size
// instance, frame/vsync timing on a second instance with a shortened vertical frame.
module tb_vga_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] r, g, b;
    logic       blank_n, vclk, hs, vs, sync_n;
    logic [7:0] s_r, s_g, s_b;
    logic       s_blank_n, s_vclk, s_hs, s_vs, s_sync_n;

    int total = 0;
    int bad   = 0;
    int ecount = 0;

    always #5 clk = ~clk;

    vga_controller u_dut (
        .CLOCK_50(clk), .reset(reset),
        .VGA_B(b), .VGA_BLANK_N(blank_n), .VGA_CLK(vclk), .VGA_G(g),
        .VGA_HS(hs), .VGA_R(r), .VGA_SYNC_N(sync_n), .VGA_VS(vs)
    );

    // 15-line frame: visible 0..7, vsync on lines 10..11.
    vga_controller #(.V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3)) u_small (
        .CLOCK_50(clk), .reset(reset),
        .VGA_B(s_b), .VGA_BLANK_N(s_blank_n), .VGA_CLK(s_vclk), .VGA_G(s_g),
        .VGA_HS(s_hs), .VGA_R(s_r), .VGA_SYNC_N(s_sync_n), .VGA_VS(s_vs)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: got=%0h", tag, got);
        end
    endtask

    // Advance to CLOCK_50 edge e after reset release, then sample 1 time unit later.
    task automatic to_edge(input int e);
        while (ecount < e) begin
            @(posedge clk);
            ecount++;
        end
        #1;
    endtask

    function automatic int tick_edge(input int t);
        return 2 + 2 * t;
    endfunction

    task automatic chk_pix(input string tag, input int t, input logic [23:0] rgb_exp,
                           input logic blank_exp);
        to_edge(tick_edge(t));
        chk({tag, " rgb"}, {8'h00, r, g, b}, {8'h00, rgb_exp});
        chk({tag, " blank"}, {31'd0, blank_n}, {31'd0, blank_exp});
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " vclk"}, {31'd0, vclk}, 32'd0);
        chk({tag, " hs"}, {31'd0, hs}, 32'd1);
        chk({tag, " vs"}, {31'd0, vs}, 32'd1);
        chk({tag, " blank"}, {31'd0, blank_n}, 32'd0);
        chk({tag, " rgb"}, {8'h00, r, g, b}, 32'd0);
        chk({tag, " sync_n"}, {31'd0, sync_n}, 32'd0);
    endtask

    initial begin
        int hs_low, ck_hi, bl_low, vs_low, xcnt, first_hs_low;
        int s_vs_low, s_first_vs, s_bl_hi, s_hs_low, b_vs_low, b_first_hs;

        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk_reset_vals("reset");

        reset  = 1'b0;
        ecount = 0;
        to_edge(1);
        chk("edge1 vclk", {31'd0, vclk}, 32'd1);
        chk("edge1 blank", {31'd0, blank_n}, 32'd0);
        to_edge(2);
        chk("tick0 vclk", {31'd0, vclk}, 32'd0);

        chk_pix("tick0 white",     0, 24'hFFFFFF, 1'b1);
        chk_pix("tick79 white",   79, 24'hFFFFFF, 1'b1);
        chk_pix("tick80 yellow",  80, 24'hFFFF00, 1'b1);
        chk_pix("tick160 cyan",  160, 24'h00FFFF, 1'b1);
        chk_pix("tick240 green", 240, 24'h00FF00, 1'b1);
        chk_pix("tick320 magenta", 320, 24'hFF00FF, 1'b1);
        chk_pix("tick400 red",   400, 24'hFF0000, 1'b1);
        chk_pix("tick480 blue",  480, 24'h0000FF, 1'b1);
        chk_pix("tick560 black", 560, 24'h000000, 1'b1);
        chk_pix("tick639 black", 639, 24'h000000, 1'b1);
        chk_pix("tick640 blank", 640, 24'h000000, 1'b0);
        to_edge(tick_edge(655));
        chk("tick655 hs", {31'd0, hs}, 32'd1);
        to_edge(tick_edge(656));
        chk("tick656 hs", {31'd0, hs}, 32'd0);
        to_edge(tick_edge(751));
        chk("tick751 hs", {31'd0, hs}, 32'd0);
        to_edge(tick_edge(752));
        chk("tick752 hs", {31'd0, hs}, 32'd1);
        chk_pix("tick799 blank", 799, 24'h000000, 1'b0);
        chk_pix("line1 tick0 white", 800, 24'hFFFFFF, 1'b1);

        // Whole of line 1, sampled every CLOCK_50 cycle.
        hs_low = 0; ck_hi = 0; bl_low = 0; vs_low = 0; xcnt = 0; first_hs_low = -1;
        for (int i = 0; i < 1600; i++) begin
            if (!hs) begin
                hs_low++;
                if (first_hs_low < 0) first_hs_low = ecount;
            end
            if (vclk) ck_hi++;
            if (!blank_n) bl_low++;
            if (!vs) vs_low++;
            if ($isunknown({r, g, b, blank_n, hs, vs, vclk, sync_n})) xcnt++;
            to_edge(ecount + 1);
        end
        chk("line1 hs low cycles", hs_low, 32'd192);
        chk("line1 hs first low edge", first_hs_low, 32'd2914);
        chk("line1 vclk high cycles", ck_hi, 32'd800);
        chk("line1 blank cycles", bl_low, 32'd320);
        chk("line1 vs low cycles", vs_low, 32'd0);
        chk("line1 x samples", xcnt, 32'd0);

        // Line 10, h=300: green bar, then a one-cycle reset.
        chk_pix("line10 h300 green", 10 * 800 + 300, 24'h00FF00, 1'b1);
        chk("line10 vs", {31'd0, vs}, 32'd1);
        chk("line10 hs", {31'd0, hs}, 32'd1);
        reset = 1'b1;
        to_edge(ecount + 1);
        chk_reset_vals("midframe reset");
        reset  = 1'b0;
        ecount = 0;

        // One full short frame on u_small; u_dut must restart at (0,0).
        to_edge(2);
        chk("restart tick0 rgb", {8'h00, r, g, b}, 32'h00FFFFFF);
        chk("restart tick0 blank", {31'd0, blank_n}, 32'd1);
        s_vs_low = 0; s_first_vs = -1; s_bl_hi = 0; s_hs_low = 0; b_vs_low = 0; b_first_hs = -1;
        for (int i = 0; i < 24000; i++) begin
            if (!s_vs) begin
                s_vs_low++;
                if (s_first_vs < 0) s_first_vs = ecount;
            end
            if (s_blank_n) s_bl_hi++;
            if (!s_hs) s_hs_low++;
            if (!vs) b_vs_low++;
            if (!hs && b_first_hs < 0) b_first_hs = ecount;
            to_edge(ecount + 1);
        end
        chk("restart hs first low edge", b_first_hs, 32'd1314);
        chk("full vs low over 15 lines", b_vs_low, 32'd0);
        chk("small vs low cycles", s_vs_low, 32'd3200);
        chk("small vs first low edge", s_first_vs, 32'd16002);
        chk("small blank_n high cycles", s_bl_hi, 32'd10240);
        chk("small hs low cycles", s_hs_low, 32'd2880);
        chk("small sync_n", {31'd0, s_sync_n}, 32'd0);
        // Next frame of u_small starts at edge 24002 with a white visible pixel.
        chk("small frame2 rgb", {8'h00, s_r, s_g, s_b}, 32'h00FFFFFF);
        chk("small frame2 blank", {31'd0, s_blank_n}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
